// File: rtl/tsu_pkg.sv
// Shared constants, FSM encodings and queue entry type for the PTP timestamp unit.
// TSU_SEQID_EN extends the header parse through sequenceId; otherwise it ends at messageType.
package tsu_pkg;

  localparam logic [15:0] PTP_ETHERTYPE = 16'h88F7;
  localparam int unsigned OFF_ETYPE     = 12;
  localparam int unsigned OFF_MSGID     = 14;
  localparam int unsigned OFF_SEQID     = 44;

`ifdef TSU_SEQID_EN
  localparam int unsigned OFF_LAST = OFF_SEQID + 1;
`else
  localparam int unsigned OFF_LAST = OFF_MSGID;
`endif

  localparam int unsigned CNT_W      = 11;
  localparam int unsigned ENTRY_TS_W = 80;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;

  typedef struct packed {
    logic [2:0]            port;
    logic [ENTRY_TS_W-1:0] ts;
    logic [3:0]            msgid;
    logic [15:0]           seqid;
  } tsu_entry_t;

endpackage

// File: rtl/tsu_fifo.sv
// Synchronous per-port queue of timestamp entries.
// One slot stays open so full/empty come straight from a pointer compare.
module tsu_fifo
  import tsu_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  tsu_entry_t wr_data,
  input  logic       rd_en,
  output tsu_entry_t rd_data_c,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  tsu_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          full_q, full_d, empty_q, empty_d;

  always_comb begin
    wptr_d  = wptr_q + AW'(wr_en);
    rptr_d  = rptr_q + AW'(rd_en);
    empty_d = (wptr_d == rptr_d);
    full_d  = ((wptr_d + AW'(1)) == rptr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data_c = mem_q[rptr_q];
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: rtl/tsu_axis_mp.sv
// Multi-port PTP event timestamp unit: taps AXIS byte streams, queues per port, round-robin drain.
// Define TSU_SEQID_EN to also capture sequenceId (bytes 44/45); otherwise m_seqid is 0.
module tsu_axis_mp
  import tsu_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_WIDTH   = 80
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PORTS-1:0]     s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]     s_axis_tready,
  input  logic [NUM_PORTS-1:0]     s_axis_tlast,
  input  logic [8*NUM_PORTS-1:0]   s_axis_tdata,
  input  logic [TS_WIDTH-1:0]      rtc_time_in,
  input  logic [16*NUM_PORTS-1:0]  msgid_mask,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [2:0]               m_port,
  output logic [TS_WIDTH-1:0]      m_ts,
  output logic [3:0]               m_msgid,
  output logic [15:0]              m_seqid,
  output logic [8*NUM_PORTS-1:0]   ovf_cnt
);

  localparam int unsigned PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]          st_q    [NUM_PORTS], st_d    [NUM_PORTS];
  logic [CNT_W-1:0]    cnt_q   [NUM_PORTS], cnt_d   [NUM_PORTS];
  logic [TS_WIDTH-1:0] ts_q    [NUM_PORTS], ts_d    [NUM_PORTS];
  logic [3:0]          msgid_q [NUM_PORTS], msgid_d [NUM_PORTS];
  logic [15:0]         seqid_q [NUM_PORTS], seqid_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] etype_q, etype_d;

  logic [NUM_PORTS-1:0]   push, wr_en, pop, full, empty;
  tsu_entry_t             push_entry [NUM_PORTS];
  tsu_entry_t             fifo_rd_c  [NUM_PORTS];
  logic [8*NUM_PORTS-1:0] ovf_q, ovf_d;

  logic [PIDX_W-1:0] ptr_q, ptr_d, gnt;
  logic              found, load;
  logic              m_valid_q, m_valid_d;
  tsu_entry_t        m_entry_q, m_entry_d;

  // Per-port header parser; the push decision uses this cycle's byte so tlast may land on the last header byte.
  always_comb begin : parse_c
    logic [7:0]       b;
    logic [15:0]      mk;
    logic [CNT_W-1:0] idx;
    logic             hdr_done;
    b        = '0;
    mk       = '0;
    idx      = '0;
    hdr_done = 1'b0;
    st_d     = st_q;
    cnt_d    = cnt_q;
    ts_d     = ts_q;
    msgid_d  = msgid_q;
    seqid_d  = seqid_q;
    etype_d  = etype_q;
    push     = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      b        = s_axis_tdata[8*i +: 8];
      mk       = msgid_mask[16*i +: 16];
      idx      = (st_q[i] == ST_IDLE) ? '0 : cnt_q[i];
      hdr_done = (st_q[i] == ST_BODY) || (idx == CNT_W'(OFF_LAST));
      if (s_axis_tvalid[i] && s_axis_tready[i]) begin
        if (st_q[i] == ST_IDLE) begin
          ts_d[i]    = rtc_time_in;
          st_d[i]    = ST_HDR;
          etype_d[i] = 1'b0;
          msgid_d[i] = '0;
          seqid_d[i] = '0;
        end
        cnt_d[i] = (idx == CNT_MAX) ? idx : idx + CNT_W'(1);
        if (idx == CNT_W'(OFF_ETYPE))     etype_d[i] = (b == PTP_ETHERTYPE[15:8]);
        if (idx == CNT_W'(OFF_ETYPE + 1)) etype_d[i] = etype_q[i] && (b == PTP_ETHERTYPE[7:0]);
        if (idx == CNT_W'(OFF_MSGID))     msgid_d[i] = b[3:0];
`ifdef TSU_SEQID_EN
        if (idx == CNT_W'(OFF_SEQID))     seqid_d[i][15:8] = b;
        if (idx == CNT_W'(OFF_SEQID + 1)) seqid_d[i][7:0]  = b;
`endif
        if (st_q[i] == ST_HDR && idx == CNT_W'(OFF_LAST)) st_d[i] = ST_BODY;
        if (s_axis_tlast[i]) begin
          st_d[i] = ST_IDLE;
          push[i] = etype_d[i] && hdr_done && mk[msgid_d[i]];
        end
      end
      push_entry[i] = '{port: 3'(i), ts: ENTRY_TS_W'(ts_d[i]),
                        msgid: msgid_d[i], seqid: seqid_d[i]};
    end
  end

  // Round-robin search from ptr_q; the output register reloads whenever it is empty or being taken.
  always_comb begin : arb_c
    logic [3:0] p;
    p         = '0;
    load      = !m_valid_q || m_ready;
    found     = 1'b0;
    gnt       = '0;
    pop       = '0;
    ptr_d     = ptr_q;
    m_valid_d = m_valid_q;
    m_entry_d = m_entry_q;
    for (int k = 0; k < int'(NUM_PORTS); k++) begin
      p = 4'(ptr_q) + 4'(k);
      if (p >= 4'(NUM_PORTS)) p = p - 4'(NUM_PORTS);
      if (!found && !empty[PIDX_W'(p)]) begin
        found = 1'b1;
        gnt   = PIDX_W'(p);
      end
    end
    if (load) begin
      m_valid_d = found;
      if (found) begin
        m_entry_d = fifo_rd_c[gnt];
        pop[gnt]  = 1'b1;
        ptr_d     = (gnt == PIDX_W'(NUM_PORTS - 1)) ? '0 : gnt + PIDX_W'(1);
      end
    end
  end

  // A push into a full queue survives only if that queue is popped in the same cycle.
  always_comb begin : ovf_c
    ovf_d = ovf_q;
    wr_en = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      wr_en[i] = push[i] && (!full[i] || pop[i]);
      if (push[i] && full[i] && !pop[i] && ovf_q[8*i +: 8] != 8'hFF)
        ovf_d[8*i +: 8] = ovf_q[8*i +: 8] + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        st_q[i]    <= ST_IDLE;
        cnt_q[i]   <= '0;
        ts_q[i]    <= '0;
        msgid_q[i] <= '0;
        seqid_q[i] <= '0;
      end
      etype_q   <= '0;
      ovf_q     <= '0;
      ptr_q     <= '0;
      m_valid_q <= 1'b0;
      m_entry_q <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      ts_q      <= ts_d;
      msgid_q   <= msgid_d;
      seqid_q   <= seqid_d;
      etype_q   <= etype_d;
      ovf_q     <= ovf_d;
      ptr_q     <= ptr_d;
      m_valid_q <= m_valid_d;
      m_entry_q <= m_entry_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_q
    tsu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en[g]),
      .wr_data   (push_entry[g]),
      .rd_en     (pop[g]),
      .rd_data_c (fifo_rd_c[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  assign m_valid = m_valid_q;
  assign m_port  = m_entry_q.port;
  assign m_ts    = TS_WIDTH'(m_entry_q.ts);
  assign m_msgid = m_entry_q.msgid;
  assign m_seqid = m_entry_q.seqid;
  assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_tsu_axis_mp.sv
// Directed bench for tsu_axis_mp: vector table of single frames plus overflow, arbitration and reset sequences.
`timescale 1ns/1ps
module tb_tsu_axis_mp;

  localparam int NP = 4;
`ifdef TSU_SEQID_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif
  localparam int HDR_LEN  = SEQ_EN ? 46 : 15;
  localparam int RUNT_LEN = SEQ_EN ? 40 : 14;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [8*NP-1:0]  s_axis_tdata;
  logic [79:0]      rtc_time_in;
  logic [16*NP-1:0] msgid_mask;
  logic             m_valid, m_ready;
  logic [2:0]       m_port;
  logic [79:0]      m_ts;
  logic [3:0]       m_msgid;
  logic [15:0]      m_seqid;
  logic [8*NP-1:0]  ovf_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tsu_axis_mp #(.NUM_PORTS(NP), .FIFO_DEPTH(8), .TS_WIDTH(80)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .rtc_time_in   (rtc_time_in),
    .msgid_mask    (msgid_mask),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_port        (m_port),
    .m_ts          (m_ts),
    .m_msgid       (m_msgid),
    .m_seqid       (m_seqid),
    .ovf_cnt       (ovf_cnt)
  );

  typedef struct {
    int          port;
    int          len;
    logic [15:0] et;
    logic [3:0]  mid;
    logic [15:0] mask;
    logic [79:0] ts;
    bit          exp;
  } vec_t;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fbyte(input int b, input logic [15:0] et,
                                       input logic [3:0] mid, input logic [15:0] sid);
    case (b)
      12:      return et[15:8];
      13:      return et[7:0];
      14:      return {4'hA, mid};
      44:      return sid[15:8];
      45:      return sid[7:0];
      default: return 8'(b);
    endcase
  endfunction

  // Drives one frame on every port in pm; one tvalid-without-tready cycle precedes byte 13.
  task automatic send(input logic [NP-1:0] pm, input int len, input logic [15:0] et,
                      input logic [3:0] mid, input logic [15:0] sid,
                      input logic [79:0] ts0, input int rst_at);
    logic [79:0] t;
    t = ts0;
    for (int b = 0; b < len; b++) begin
      if (b == 13) begin
        s_axis_tvalid = pm;
        s_axis_tready = '0;
        s_axis_tdata  = {NP{8'hEE}};
        s_axis_tlast  = '0;
        rtc_time_in   = t;
        t             = t + 80'd1;
        tick();
      end
      s_axis_tvalid = pm;
      s_axis_tready = '1;
      s_axis_tdata  = {NP{fbyte(b, et, mid, sid)}};
      s_axis_tlast  = (b == len - 1) ? pm : '0;
      rst           = (b == rst_at);
      rtc_time_in   = t;
      t             = t + 80'd1;
      tick();
    end
    rst           = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    vec_t        vt [9];
    logic [15:0] exp_sid;
    rst           = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tready = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    rtc_time_in   = '0;
    msgid_mask    = '0;
    m_ready       = 1'b0;
    exp_sid       = SEQ_EN ? 16'h1234 : 16'h0000;

    vt[0] = '{0, 60,       16'h88F7, 4'h0, 16'h0001, 80'h0000_0000_0000_0000_0100, 1'b1};
    vt[1] = '{0, 60,       16'h88F7, 4'h0, 16'h0000, 80'h0000_0000_0000_0000_0200, 1'b0};
    vt[2] = '{0, 60,       16'h0800, 4'h0, 16'h0001, 80'h0000_0000_0000_0000_0300, 1'b0};
    vt[3] = '{0, RUNT_LEN, 16'h88F7, 4'h0, 16'h0001, 80'h0000_0000_0000_0000_0400, 1'b0};
    vt[4] = '{2, 50,       16'h88F7, 4'h3, 16'h0008, 80'h0001_0000_0002_2345_6789, 1'b1};
    vt[5] = '{3, HDR_LEN,  16'h88F7, 4'h3, 16'h0008, 80'h0000_00AB_0000_0000_0050, 1'b1};
    vt[6] = '{1, 60,       16'h88F7, 4'h5, 16'hFFDF, 80'h0000_0000_0000_0000_0600, 1'b0};
    vt[7] = '{1, 60,       16'h88F7, 4'hB, 16'h0800, 80'h0000_0000_0000_0000_0700, 1'b1};
    vt[8] = '{0, 60,       16'h88F8, 4'h0, 16'h0001, 80'h0000_0000_0000_0000_0800, 1'b0};

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_m_valid", 80'(m_valid), 80'd0);
    chk("rst_m_port",  80'(m_port),  80'd0);
    chk("rst_m_ts",    m_ts,         80'd0);
    chk("rst_m_msgid", 80'(m_msgid), 80'd0);
    chk("rst_m_seqid", 80'(m_seqid), 80'd0);
    chk("rst_ovf",     80'(ovf_cnt), 80'd0);

    for (int v = 0; v < 9; v++) begin
      msgid_mask = '0;
      msgid_mask[16*vt[v].port +: 16] = vt[v].mask;
      send(4'(1) << vt[v].port, vt[v].len, vt[v].et, vt[v].mid, 16'h1234, vt[v].ts, -1);
      chk($sformatf("v%0d_valid_lat1", v), 80'(m_valid), 80'd0);
      tick();
      chk($sformatf("v%0d_valid", v), 80'(m_valid), 80'(vt[v].exp));
      if (vt[v].exp) begin
        chk($sformatf("v%0d_port", v),  80'(m_port),  80'(vt[v].port));
        chk($sformatf("v%0d_ts", v),    m_ts,         vt[v].ts);
        chk($sformatf("v%0d_msgid", v), 80'(m_msgid), 80'(vt[v].mid));
        chk($sformatf("v%0d_seqid", v), 80'(m_seqid), 80'(exp_sid));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk($sformatf("v%0d_drained", v), 80'(m_valid), 80'd0);
      end
      chk($sformatf("v%0d_ovf", v), 80'(ovf_cnt), 80'd0);
    end

    // Overflow: 9 frames into port 1 under backpressure, then 300 more drops.
    do_reset();
    msgid_mask = '0;
    msgid_mask[31:16] = 16'h0001;
    for (int f = 0; f < 9; f++)
      send(4'b0010, HDR_LEN, 16'h88F7, 4'h0, 16'(f), 80'(f) * 80'h10000 + 80'd5, -1);
    repeat (2) tick();
    chk("ovf_p1_one", 80'(ovf_cnt[15:8]), 80'd1);
    chk("ovf_others", 80'({ovf_cnt[31:16], ovf_cnt[7:0]}), 80'd0);
    chk("hold_valid", 80'(m_valid), 80'd1);
    repeat (3) tick();
    chk("hold_ts", m_ts, 80'd5);
    for (int f = 0; f < 300; f++)
      send(4'b0010, HDR_LEN, 16'h88F7, 4'h0, 16'h00FF, 80'hFFFF_0000, -1);
    chk("ovf_sat", 80'(ovf_cnt[15:8]), 80'd255);
    m_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("drain%0d_valid", n), 80'(m_valid), 80'd1);
      chk($sformatf("drain%0d_ts", n),    m_ts, 80'(n) * 80'h10000 + 80'd5);
      chk($sformatf("drain%0d_port", n),  80'(m_port), 80'd1);
      tick();
    end
    chk("drain_empty", 80'(m_valid), 80'd0);
    chk("ovf_sat_hold", 80'(ovf_cnt[15:8]), 80'd255);

    // Round-robin: simultaneous frames, then a single port-2 grant moves the start to port 3.
    do_reset();
    m_ready    = 1'b1;
    msgid_mask = {NP{16'h0001}};
    send(4'b1111, HDR_LEN, 16'h88F7, 4'h0, 16'h1234, 80'h1000, -1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr1_%0d_valid", k), 80'(m_valid), 80'd1);
      chk($sformatf("rr1_%0d_port", k),  80'(m_port),  80'(k));
      tick();
    end
    chk("rr1_idle", 80'(m_valid), 80'd0);
    send(4'b0100, HDR_LEN, 16'h88F7, 4'h0, 16'h1234, 80'h2000, -1);
    tick();
    chk("rr_p2_port", 80'(m_port), 80'd2);
    tick();
    send(4'b1111, HDR_LEN, 16'h88F7, 4'h0, 16'h1234, 80'h3000, -1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr2_%0d_valid", k), 80'(m_valid), 80'd1);
      chk($sformatf("rr2_%0d_port", k),  80'(m_port),  80'((k + 3) % 4));
      tick();
    end
    chk("rr2_idle", 80'(m_valid), 80'd0);

    // Reset at byte 20 discards the frame; the next frame is captured normally.
    m_ready    = 1'b0;
    msgid_mask = '0;
    msgid_mask[15:0] = 16'h0001;
    send(4'b0001, 60, 16'h88F7, 4'h0, 16'h1234, 80'h4000, 20);
    repeat (3) tick();
    chk("midrst_no_entry", 80'(m_valid), 80'd0);
    chk("midrst_ovf",      80'(ovf_cnt), 80'd0);
    send(4'b0001, 60, 16'h88F7, 4'h2, 16'hBEEF, 80'h5000, -1);
    msgid_mask[15:0] = 16'h0004;
    chk("post_lat1", 80'(m_valid), 80'd0);
    tick();
    chk("post_valid", 80'(m_valid), 80'd0);
    msgid_mask[15:0] = 16'h0004;
    send(4'b0001, 60, 16'h88F7, 4'h2, 16'hBEEF, 80'h6000, -1);
    tick();
    chk("post2_valid", 80'(m_valid), 80'd1);
    chk("post2_ts",    m_ts,         80'h6000);
    chk("post2_msgid", 80'(m_msgid), 80'd2);
    chk("post2_seqid", 80'(m_seqid), SEQ_EN ? 80'hBEEF : 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tsu_axis_mp.md
TSU_AXIS_MP -- requirements
Module: tsu_axis_mp

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: monitored AXIS byte streams, 1..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: entries per port queue, power of 2, 2..64.
REQ-003 SHALL have parameter TS_WIDTH, default 80: timestamp width, {sec[47:0], ns[31:0]}.
REQ-004 SHALL have clk  input  1: the single clock; all ports, including the AXIS taps, are synchronous to it.
REQ-005 SHALL have rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have s_axis_tvalid/s_axis_tready/s_axis_tlast  input  NUM_PORTS each: tapped handshake, one bit per port.
REQ-007 SHALL have s_axis_tdata  input  8*NUM_PORTS: tapped byte; port i is bits [8i+7:8i].
REQ-008 SHALL have rtc_time_in  input  TS_WIDTH: free-running RTC time.
REQ-009 SHALL have msgid_mask  input  16*NUM_PORTS: per-port enable, bit k set enables PTP messageType k.
REQ-010 SHALL have m_valid  output  1, m_ready  input  1: output handshake.
REQ-011 SHALL have m_port  output  3: source port index.
REQ-012 SHALL have m_ts  output  TS_WIDTH: captured timestamp.
REQ-013 SHALL have m_msgid  output  4: messageType.
REQ-014 SHALL have m_seqid  output  16: sequenceId.
REQ-015 SHALL have ovf_cnt  output  8*NUM_PORTS: per-port count of dropped entries.

Function
REQ-016 A byte is accepted on port i only when tvalid[i] && tready[i]; the tap SHALL never drive tready.
REQ-017 Each port SHALL run the FSM IDLE->HDR->BODY->IDLE, with an 11-bit byte counter starting at 0 on the first accepted byte.
REQ-018 In IDLE, the first accepted byte SHALL latch rtc_time_in of that same cycle and move the FSM to HDR.
REQ-019 In HDR, bytes 12/13 SHALL be compared with 0x88 and 0xF7; byte 14 bits[3:0] SHALL be latched as msgid; bytes 44/45 SHALL be latched as seqid[15:8]/[7:0]; after byte 45 the FSM SHALL move to BODY.
REQ-020 An accepted tlast in any state SHALL return the FSM to IDLE; the counter SHALL saturate at 2047.
REQ-021 A push SHALL occur at tlast only when the ethertype matched, byte 45 was received, and msgid_mask[16i+msgid]=1; a runt frame or masked type SHALL cause no push and no count.
REQ-022 A push into a full queue SHALL be dropped and SHALL increment ovf_cnt[i], saturating at 255.
REQ-023 Queues SHALL be drained by a round-robin arbiter, starting the search at the port after the last one granted.
REQ-024 The output SHALL be a registered skid stage: m_* SHALL be held stable while m_valid && !m_ready, and one entry SHALL be transferable per cycle.
REQ-025 Latency from the tlast cycle to m_valid SHALL be 2 cycles when the output is idle and the queue is empty.
REQ-026 A pop and a push on the same queue in the same cycle SHALL both succeed, including when the queue is full.

Reset
REQ-027 rst SHALL set every FSM to IDLE, empty every queue, and clear ovf_cnt, m_valid, m_port, m_ts, m_msgid, m_seqid and the arbiter pointer to 0.
REQ-028 rst asserted mid-frame SHALL discard the partial frame; the remainder up to tlast SHALL be treated as a new frame, whose ethertype check fails, so it is not pushed.

Configuration
REQ-029 With TSU_SEQID_EN defined, seqid SHALL be parsed as in REQ-019.
REQ-030 Without TSU_SEQID_EN, m_seqid SHALL be constant 0, the push precondition SHALL become "byte 14 received", and the FSM SHALL enter BODY after byte 14.

Structure
REQ-031 Package tsu_pkg SHALL hold PTP_ETHERTYPE=16'h88F7, OFF_ETYPE=12, OFF_MSGID=14, OFF_SEQID=44 and the typedef tsu_entry_t {port, ts, msgid, seqid}.
REQ-032 The per-port queue SHALL be the sub-module tsu_fifo, a synchronous FIFO of tsu_entry_t with full/empty outputs, instantiated NUM_PORTS times.

Verification
REQ-033 A 60-byte frame on port 0 with 0x88F7, byte14=0x00, seqid=0x1234, mask=0x0001, rtc=0x...0100 on the first byte -> one entry {0, 0x...0100, 0, 0x1234}, m_valid 2 cycles after tlast.
REQ-034 The same frame with mask=0x0000, or with ethertype 0x0800, or truncated at 40 bytes -> no entry and ovf_cnt unchanged.
REQ-035 With m_ready=0, push 9 frames into port 1 at FIFO_DEPTH=8 -> 8 entries are retained (7 queued, 1 in the output stage) and ovf_cnt[1]=1; after 300 further drops the count stays at 255.
REQ-036 Simultaneous tlast on ports 0..3 with m_ready=1 -> output order 0,1,2,3; a repeat after the last grant to port 2 -> order 3,0,1,2.
REQ-037 rst pulsed at byte 20 of a valid frame -> no entry, and a following valid frame is captured correctly.
REQ-038 Build without TSU_SEQID_EN: a 15-byte frame with 0x88F7 and msgid 3 -> one entry with m_seqid=0.
